// File: rtl/ahb_dma_master.sv
// Single-channel AHB-Lite copy engine: reads one word from src, writes it to dst,
// repeats len times. One transfer in flight at a time, every output registered.
//
// state      | meaning
// S_IDLE     | waiting for start_i, bus idle
// S_RD_ADDR  | NONSEQ read address phase at src
// S_RD_DATA  | read data phase, HRDATA captured into the buffer
// S_WR_ADDR  | NONSEQ write address phase at dst
// S_WR_DATA  | write data phase, buffer driven on HWDATA
// S_FIN      | one-cycle done_o pulse (normal end or abort)
module ahb_dma_master #(
  parameter int LEN_W = 16
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             start_i,
  input  logic [31:0]      src_addr_i,
  input  logic [31:0]      dst_addr_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [31:0]      HADDR,
  output logic [1:0]       HTRANS,
  output logic             HWRITE,
  output logic [2:0]       HSIZE,
  output logic [3:0]       HPROT,
  output logic [31:0]      HWDATA,
  input  logic [31:0]      HRDATA,
  input  logic             HREADY,
  input  logic             HRESP
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_ADDR, S_RD_DATA, S_WR_ADDR, S_WR_DATA, S_FIN
  } state_t;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;

  state_t             state_q, state_d;
  logic [31:0]        src_q, src_d;
  logic [31:0]        dst_q, dst_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        buf_q, buf_d;
  logic               err_d;

  logic [31:0]        haddr_d, hwdata_d;
  logic [1:0]         htrans_d;
  logic               hwrite_d, busy_d, done_d;

  assign HSIZE = 3'b010;
  assign HPROT = 4'b0011;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
      err_o   <= 1'b0;
      HADDR   <= '0;
      HTRANS  <= TR_IDLE;
      HWRITE  <= 1'b0;
      HWDATA  <= '0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      err_o   <= err_d;
      HADDR   <= haddr_d;
      HTRANS  <= htrans_d;
      HWRITE  <= hwrite_d;
      HWDATA  <= hwdata_d;
      busy_o  <= busy_d;
      done_o  <= done_d;
    end
  end

  // Next state plus the channel registers; an error response always aborts to S_FIN.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    err_d   = err_o;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          src_d   = src_addr_i & 32'hFFFF_FFFC;
          dst_d   = dst_addr_i & 32'hFFFF_FFFC;
          cnt_d   = len_i;
          err_d   = 1'b0;
          state_d = (len_i == '0) ? S_FIN : S_RD_ADDR;
        end
      end
      S_RD_ADDR: if (HREADY) state_d = S_RD_DATA;
      S_RD_DATA: begin
        if (HRESP) err_d = 1'b1;
        if (HREADY) begin
          if (HRESP) begin
            state_d = S_FIN;
          end else begin
            buf_d   = HRDATA;
            state_d = S_WR_ADDR;
          end
        end
      end
      S_WR_ADDR: if (HREADY) state_d = S_WR_DATA;
      S_WR_DATA: begin
        if (HRESP) err_d = 1'b1;
        if (HREADY) begin
          if (HRESP) begin
            state_d = S_FIN;
          end else begin
            src_d   = src_q + 32'd4;
            dst_d   = dst_q + 32'd4;
            cnt_d   = cnt_q - LEN_W'(1);
            state_d = (cnt_q == LEN_W'(1)) ? S_FIN : S_RD_ADDR;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are computed from the upcoming state so they appear registered in that state.
  always_comb begin
    htrans_d = TR_IDLE;
    haddr_d  = HADDR;
    hwrite_d = HWRITE;
    hwdata_d = HWDATA;
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_FIN);
    case (state_d)
      S_RD_ADDR: begin
        htrans_d = TR_NONSEQ;
        haddr_d  = src_d;
        hwrite_d = 1'b0;
      end
      S_WR_ADDR: begin
        htrans_d = TR_NONSEQ;
        haddr_d  = dst_d;
        hwrite_d = 1'b1;
      end
      S_WR_DATA: begin
        if (state_q == S_WR_ADDR) hwdata_d = buf_q;
      end
      default: ;
    endcase
  end

endmodule
